// File: rtl/imem_pkg.sv
// Shared definitions for the instruction fetch path: fetch states, queue entry
// layout and opcode constants used by decode and benches.
package imem_pkg;

    localparam int IMEM_DEPTH_DEFAULT = 128;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        HALTED = 2'd1,
        FAULT  = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam logic [31:0] NOP   = 32'h0000_0000;
    localparam logic [5:0]  LW    = 6'b100011;
    localparam logic [5:0]  SW    = 6'b101011;
    localparam logic [5:0]  RTYPE = 6'b000000;

endpackage

// File: rtl/fetch_queue.sv
// Two-entry FIFO of fetched {pc, instr} pairs; slot0 is always the head so the
// head outputs come straight from a register.
module fetch_queue
    import imem_pkg::*;
#(
    parameter int QDEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  fetch_entry_t push_entry,
    input  logic         pop,
    input  logic         flush,
    output logic         full,
    output logic         empty,
    output fetch_entry_t head
);

    logic [1:0]   count;
    fetch_entry_t slot0;
    fetch_entry_t slot1;
    logic         pop_eff;
    logic         push_eff;

    assign full     = (count == 2'(QDEPTH));
    assign empty    = (count == 2'd0);
    assign head     = slot0;
    assign pop_eff  = pop & !empty;
    assign push_eff = push & (!full | pop_eff);

    // NOTE: the data slots are reset too, so out_instr/out_pc read 0 after reset
    // instead of X; flush only clears the count, stale data is harmless.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 2'd0;
            slot0 <= '0;
            slot1 <= '0;
        end else if (flush) begin
            count <= 2'd0;
        end else begin
            case ({push_eff, pop_eff})
                2'b10: begin
                    if (empty) slot0 <= push_entry;
                    else       slot1 <= push_entry;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    slot0 <= slot1;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    // Count is unchanged; the new entry lands behind the survivor.
                    if (count == 2'd1) begin
                        slot0 <= push_entry;
                    end else begin
                        slot0 <= slot1;
                        slot1 <= push_entry;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Fetch sequencer: owns the PC, drives the instruction memory address, queues
// fetched words for decode and handles redirect, halt and out-of-range faults.
module imem_fetch_ctrl
    import imem_pkg::*;
#(
    parameter int          IMEM_DEPTH = IMEM_DEPTH_DEFAULT,
    parameter logic [31:0] RESET_PC   = 32'd0,
    parameter int          QDEPTH     = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        fault
);

    localparam logic [31:0] DEPTH_W = 32'(IMEM_DEPTH);

    fetch_state_e state, state_next;
    logic [31:0]  pc, pc_next;
    logic         q_full, q_empty;
    fetch_entry_t q_head;
    logic         pop;
    logic         pc_oor;
    logic         fetch_en;
    logic         redirect_take;

    assign imem_addr     = pc;
    assign out_valid     = !q_empty;
    assign out_instr     = q_head.instr;
    assign out_pc        = q_head.pc;
    assign fault         = (state == FAULT);

    assign pop           = out_valid & out_ready;
    assign pc_oor        = (pc >= DEPTH_W);
    assign redirect_take = redirect_valid & (state != FAULT);
    assign fetch_en      = (state == FETCH) & !halt & (!q_full | pop)
                         & !redirect_valid & !pc_oor;

    fetch_queue #(.QDEPTH(QDEPTH)) u_queue (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (fetch_en),
        .push_entry ('{pc: pc, instr: imem_data}),
        .pop        (pop),
        .flush      (redirect_take),
        .full       (q_full),
        .empty      (q_empty),
        .head       (q_head)
    );

    // NOTE: every output of this block gets a default first, so no path through
    // the case can leave a value unassigned and infer a latch.
    always_comb begin
        state_next = state;
        pc_next    = pc;
        case (state)
            FETCH: begin
                if (halt)                          state_next = HALTED;
                else if (!redirect_valid && pc_oor) state_next = FAULT;
            end
            HALTED:  if (!halt) state_next = FETCH;
            FAULT:   state_next = FAULT;
            default: state_next = FETCH;
        endcase
        if (redirect_take)  pc_next = redirect_pc;
        else if (fetch_en)  pc_next = pc + 32'd1;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values computed above, independent of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FETCH;
            pc    <= RESET_PC;
        end else begin
            state <= state_next;
            pc    <= pc_next;
        end
    end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Randomised bench for imem_fetch_ctrl against a queue-based reference model,
// with directed sequences for reset, stall, redirect, halt and fault.
module tb_imem_fetch_ctrl;
    import imem_pkg::*;

    localparam int          DEPTH   = 16;
    localparam logic [31:0] DEPTH_W = 32'd16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        halt = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        fault;

    logic [31:0] mem [DEPTH];

    int n_vec = 0;
    int n_err = 0;

    // Reference model: mode 0 = running, 1 = halted, 2 = faulted.
    logic [31:0] m_pc;
    logic [31:0] m_qpc [$];
    logic [31:0] m_qins [$];
    int          m_mode;

    always #5 clk = ~clk;

    assign imem_data = (imem_addr < DEPTH_W) ? mem[imem_addr[3:0]] : 32'hBAD0_0BAD;

    imem_fetch_ctrl #(.IMEM_DEPTH(DEPTH), .RESET_PC(32'd0), .QDEPTH(2)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .fault          (fault)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc   = 32'd0;
        m_mode = 0;
        m_qpc.delete();
        m_qins.delete();
    endtask

    // Advance the model by one clock edge using the currently driven inputs.
    task automatic model_edge();
        bit pop;
        bit space;
        pop   = (m_qpc.size() > 0) && out_ready;
        space = (m_qpc.size() < 2) || pop;
        if (pop) begin
            void'(m_qpc.pop_front());
            void'(m_qins.pop_front());
        end
        if (m_mode != 2 && redirect_valid) begin
            m_qpc.delete();
            m_qins.delete();
            m_pc = redirect_pc;
            if (m_mode == 0 && halt)       m_mode = 1;
            else if (m_mode == 1 && !halt) m_mode = 0;
        end else if (m_mode == 0 && !halt) begin
            if (m_pc >= DEPTH_W) begin
                m_mode = 2;
            end else if (space) begin
                m_qpc.push_back(m_pc);
                m_qins.push_back(mem[m_pc[3:0]]);
                m_pc = m_pc + 32'd1;
            end
        end else if (m_mode == 0 && halt) begin
            m_mode = 1;
        end else if (m_mode == 1 && !halt) begin
            m_mode = 0;
        end
    endtask

    task automatic compare_all();
        check("out_valid", 64'(out_valid), 64'(m_qpc.size() > 0));
        check("imem_addr", 64'(imem_addr), 64'(m_pc));
        check("fault", 64'(fault), 64'(m_mode == 2));
        if (m_qpc.size() > 0) begin
            check("out_pc", 64'(out_pc), 64'(m_qpc[0]));
            check("out_instr", 64'(out_instr), 64'(m_qins[0]));
        end
    endtask

    task automatic step(input logic rdy, input logic hl, input logic rv, input logic [31:0] rpc);
        out_ready      = rdy;
        halt           = hl;
        redirect_valid = rv;
        redirect_pc    = rpc;
        model_edge();
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    // Assert reset between edges, check the asynchronous effect, release on a falling edge.
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_fault", 64'(fault), 64'd0);
        check("rst_imem_addr", 64'(imem_addr), 64'd0);
        @(negedge clk);
        redirect_valid = 1'b0;
        halt           = 1'b0;
        rst_n          = 1'b1;
        compare_all();
    endtask

    initial begin
        logic [31:0] w;
        logic [31:0] frozen;
        logic [5:0]  ops [3];
        ops[0] = LW; ops[1] = SW; ops[2] = RTYPE;
        for (int i = 0; i < DEPTH; i++) begin
            w = $urandom();
            mem[i] = {ops[$urandom_range(0, 2)], w[25:0]};
        end
        mem[0] = 32'h8C01_0001;
        mem[9] = 32'h00A5_2820;
        model_reset();

        // Reset values and first-fetch latency.
        @(negedge clk);
        check("rst_out_instr", 64'(out_instr), 64'd0);
        check("rst_out_pc", 64'(out_pc), 64'd0);
        do_reset();
        step(1'b1, 1'b0, 1'b0, 32'd0);
        check("t1_valid", 64'(out_valid), 64'd1);
        check("t1_pc", 64'(out_pc), 64'd0);
        check("t1_instr", 64'(out_instr), 64'h8C01_0001);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 32'd0);
        check("t1_stream_pc", 64'(out_pc), 64'd4);

        // Backpressure fills the queue, then drains without a gap.
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 32'd0);
        check("t2_addr_hold", 64'(imem_addr), 64'd2);
        check("t2_head_hold", 64'(out_pc), 64'd0);
        step(1'b1, 1'b0, 1'b0, 32'd0);
        check("t2_pc1", 64'(out_pc), 64'd1);
        step(1'b1, 1'b0, 1'b0, 32'd0);
        check("t2_pc2", 64'(out_pc), 64'd2);

        // Redirect while the queue holds pc 4,5.
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b0, 1'b0, 32'd0);
        check("t3_head4", 64'(out_pc), 64'd4);
        step(1'b0, 1'b0, 1'b1, 32'd9);
        check("t3_flush", 64'(out_valid), 64'd0);
        step(1'b1, 1'b0, 1'b0, 32'd0);
        check("t3_pc9", 64'(out_pc), 64'd9);
        check("t3_instr9", 64'(out_instr), 64'h00A5_2820);

        // Halt drains the queue and freezes the PC.
        frozen = imem_addr;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 32'd0);
        check("t4_frozen", 64'(imem_addr), 64'(frozen));
        check("t4_drained", 64'(out_valid), 64'd0);
        step(1'b1, 1'b0, 1'b0, 32'd0);
        step(1'b1, 1'b0, 1'b0, 32'd0);
        check("t4_resume", 64'(out_pc), 64'(frozen));

        // Run off the end of memory, then try a redirect out of the fault.
        step(1'b1, 1'b0, 1'b1, 32'd13);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, 32'd0);
        check("t5_fault", 64'(fault), 64'd1);
        check("t5_empty", 64'(out_valid), 64'd0);
        step(1'b1, 1'b0, 1'b1, 32'd2);
        check("t5_redir_ignored", 64'(imem_addr), 64'(DEPTH_W));
        check("t5_sticky", 64'(fault), 64'd1);

        // Asynchronous reset out of the fault state.
        do_reset();
        step(1'b1, 1'b0, 1'b0, 32'd0);
        check("t6_restart", 64'(out_pc), 64'd0);

        // Randomised traffic with occasional mid-stream resets.
        for (int i = 0; i < 2000; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 19) == 0, 32'($urandom_range(0, 19)));
            if (i % 250 == 249) do_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/imem_fetch_ctrl.md
Name: imem_fetch_ctrl

Overview:
- Instruction fetch sequencer between the program counter and the instruction memory (combinational, word-indexed read port).
- Owns the PC and issues one word address per cycle.
- Buffers fetched words with their PC in a 2-entry queue and hands them to decode over a valid/ready handshake.
- Handles branch/jump redirects (with flush), halt, and out-of-range PC faults.

Parameters:
IMEM_DEPTH, 128, number of valid instruction words; legal PC range 0..IMEM_DEPTH-1
RESET_PC, 0, word address fetched first after reset
QDEPTH, 2, fetch queue entries (fixed at 2; other values unsupported)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous, active-low reset
imem_addr  out  32  word address to instruction memory; equals pc
imem_data  in  32  read data for imem_addr, valid in the same cycle
redirect_valid  in  1  single-cycle pulse: taken branch/jump
redirect_pc  in  32  target word address, sampled when redirect_valid=1
halt  in  1  level: suspend new fetches while high
out_valid  out  1  queue head valid
out_ready  in  1  decode accepts head this cycle
out_instr  out  32  head instruction word
out_pc  out  32  head instruction word address
fault  out  1  sticky: fetch attempted at pc >= IMEM_DEPTH

Behaviour:
- Reset (rst_n=0, asynchronous): pc=RESET_PC, queue empty, state=FETCH.
  - Output reset values: out_valid=0, out_instr=0, out_pc=0, fault=0.
- Clock and reset: one clock, clk. Reset is asynchronous, active-low (rst_n); release is taken synchronously to clk.
- Reset mid-operation discards queue contents and any pending redirect immediately.
- States:
  - FETCH: normal operation.
  - HALTED: entered when halt=1 in FETCH; back to FETCH when halt=0.
  - FAULT: terminal until reset.
- Definitions:
  - pop = out_valid & out_ready.
  - fetch_en = (state==FETCH) & !halt & (count<2 | pop) & !redirect_valid.
  - imem_addr = pc always (combinational).
- On fetch_en, at the edge: push {imem_data, pc}; pc <= pc+1 (32-bit, wraps at 2^32).
- Out-of-range PC: if state==FETCH, !halt and pc >= IMEM_DEPTH:
  - no push; state <= FAULT; fault <= 1.
  - Entries already queued still drain normally.
- Latency: first out_valid=1 one cycle after the first edge with rst_n=1; out_pc=RESET_PC.
- Throughput: 1 instruction/cycle with out_ready held high.
- Queue:
  - Push and pop in the same cycle are allowed at count 0, 1 or 2.
  - Count unchanged when full with pop.
  - No push when full without pop; pc holds.
  - Head outputs are stable while out_valid=1 and out_ready=0.
- Redirect (highest priority, any state except FAULT):
  - Queue flushed; pc <= redirect_pc; no push that cycle; out_valid=0 next cycle.
  - A pop in the same cycle is still counted as consumed by decode.
  - Next fetch is from redirect_pc on the following cycle; first redirected instruction is out_valid two edges after the redirect.
- Redirect while HALTED: pc updated; fetching waits for halt=0.
- Redirect in FAULT: ignored.
- halt does not block pops.
- out_instr/out_pc are don't-care when out_valid=0 but are driven from the queue head; no X propagation.

Decomposition:
- Shared package imem_pkg:
  - IMEM_DEPTH default
  - fetch state encoding (FETCH=2'd0, HALTED=2'd1, FAULT=2'd2)
  - NOP constant 32'h0000_0000
  - opcode constants LW=6'b100011, SW=6'b101011, RTYPE=6'b000000, for decode and benches
- Sub-module fetch_queue: 2-entry FIFO of {pc[31:0], instr[31:0]}.
  - Ports: push, pop, flush, full, empty, head.
  - Same clk/rst_n conventions.
- The top level holds the PC, state machine and fetch_en logic.

Test Plan:
1. Reset release, out_ready=1, memory holds LW r1,1(r0)=32'h8C01_0001 at word 0.
   -> Cycle 1: out_valid=1, out_pc=0, out_instr=32'h8C01_0001.
   -> Then out_pc 1,2,3... on consecutive cycles.
2. out_ready=0 for 5 cycles after reset.
   -> Queue fills with pc 0,1; imem_addr holds at 2; out_pc stays 0.
   -> Raising out_ready yields out_pc 0,1,2 back-to-back with no gap.
3. Redirect: redirect_valid pulse with redirect_pc=9 while the queue holds pc 4,5.
   -> Next cycle out_valid=0.
   -> Then out_pc=9 with out_instr = word 9 (32'h00A5_2820, ADD r5,r5,r5).
   -> pc 4,5 never appear after the redirect.
4. halt=1 for 3 cycles with out_ready=1.
   -> Queued entries drain, then out_valid=0.
   -> imem_addr frozen; fetch resumes at the frozen pc after halt=0.
5. IMEM_DEPTH=4, free-running.
   -> out_pc 0..3 delivered; fault=1 when pc=4; out_valid falls after draining.
   -> A later redirect is ignored; fault clears only on rst_n=0.
6. Assert rst_n=0 asynchronously mid-stream, between edges.
   -> out_valid=0 and fault=0 immediately, without waiting for an edge.
   -> After release, fetch restarts at RESET_PC.
